// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and the memory byte-swap shared with fetch
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, ERR, RESP} state_t;
  // Memory returns byte A on [31:24]; reorder so byte A lands on [7:0]
  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response handshake plus memory data port
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_wen, mem_wdata
  );
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/lsu_lane.sv
// lsu_lane: lane extraction/extension for loads and lane merge for sub-word stores
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] lw,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] ld,
  output logic [31:0] st
);
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask;
  logic [31:0] ins;
  always_comb begin
    sh = {off, 3'b000};
    b = lw[sh +: 8];
    h = off[1] ? lw[31:16] : lw[15:0];
    ld = funct3 == F3_B  ? {{24{b[7]}}, b} :
         funct3 == F3_H  ? {{16{h[15]}}, h} :
         funct3 == F3_W  ? lw :
         funct3 == F3_BU ? {24'b0, b} :
         funct3 == F3_HU ? {16'b0, h} : '0;
    mask = funct3 == F3_H ? 32'h0000_FFFF << {off[1], 4'b0000} : 32'h0000_00FF << sh;
    ins = funct3 == F3_H ? {16'b0, wdata} << {off[1], 4'b0000} : {24'b0, wdata[7:0]} << sh;
    st = (lw & ~mask) | ins;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: word-aligned RV32I load/store master with read-modify-write sub-word stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 512
) (
  input logic clock,
  input logic reset,
  load_store_unit_if.slave bus
);
  state_t      state, next;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [31:0] r_wdata, merge, rdata_q, addr_q, wdata_q, lw, ld, st, aligned;
  logic        err_q, valid_q, wen_q, accept, legal, misaligned, err;
  assign lw = bswap(bus.mem_rdata);
  lsu_lane u_lane (
    .lw    (lw),
    .off   (r_off),
    .funct3(r_f3),
    .wdata (r_wdata[15:0]),
    .ld    (ld),
    .st    (st)
  );
  always_comb begin
    accept = state == IDLE && bus.req_valid;
    aligned = {bus.req_addr[31:2], 2'b00};
    legal = bus.req_funct3 inside {F3_B, F3_H, F3_W} ||
            (!bus.req_write && bus.req_funct3 inside {F3_BU, F3_HU});
    misaligned = (bus.req_funct3 inside {F3_H, F3_HU} && bus.req_addr[0]) ||
                 (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00);
    err = !legal || misaligned || aligned > 32'(MEM_BYTES - 4);
    next = state;
    case (state)
      IDLE:             next = !accept ? IDLE : err ? ERR : !bus.req_write ? LOAD :
                               bus.req_funct3 == F3_W ? WRITE : MERGE;
      LOAD, WRITE, ERR: next = RESP;
      MERGE:            next = WRITE;
      RESP:             next = valid_q && bus.resp_ready ? IDLE : RESP;
      default:          next = IDLE;
    endcase
  end
  // Handshake outputs are registered, so they trail the state by one edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wen_q <= 1'b0;
    end else begin
      state <= next;
      valid_q <= state == RESP && !(valid_q && bus.resp_ready);
      wen_q <= state == WRITE;
      if (accept) begin
        r_f3 <= bus.req_funct3;
        r_off <= bus.req_addr[1:0];
        r_wdata <= bus.req_wdata;
        rdata_q <= '0;
        err_q <= err;
        if (!err) addr_q <= aligned;
      end
      if (state == LOAD) rdata_q <= ld;
      if (state == MERGE) merge <= st;
      if (state == WRITE) wdata_q <= r_f3 == F3_W ? r_wdata : merge;
    end
  end
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = err_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wen = wen_q && !reset;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed requests checked every cycle against a byte-array reference model
module tb_load_store_unit;
  import lsu_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  load_store_unit_if bus();
  load_store_unit #(.MEM_BYTES(512)) dut (.clock(clock), .reset(reset), .bus(bus));
  logic [7:0] mem [512] = '{default: 8'h00};
  logic [7:0] ref_mem [512] = '{default: 8'h00};
  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  logic last_rst = 1'b1;
  typedef struct {
    int          n;
    int          r;
    int          w;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] waddr;
    logic [31:0] wword;
  } tx_t;
  tx_t q[$];
  tx_t cur;
  logic ev, wev;
  logic [8:0] ra;
  // Memory with the mixed byte order: little-endian writes, big-endian reads
  assign ra = bus.mem_addr[8:0];
  assign bus.mem_rdata = bus.mem_addr <= 32'd508 ?
    {mem[ra], mem[ra + 9'd1], mem[ra + 9'd2], mem[ra + 9'd3]} : 32'h0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    last_rst <= reset;
    if (bus.mem_wen)
      for (int i = 0; i < 4; i++) mem[ra + 9'(i)] <= bus.mem_wdata[8*i +: 8];
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // Reference: response and memory effect computed straight from the ISA rules
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit apply, output logic [31:0] r,
                       output logic e, output int lat, output bit wr, output logic [31:0] ww);
    int sz;
    bit sgn;
    bit legal;
    logic [31:0] al, val;
    al = a & ~32'd3;
    sz = 0;
    sgn = 1'b0;
    case (f3)
      3'b000: begin sz = 1; sgn = 1'b1; end
      3'b001: begin sz = 2; sgn = 1'b1; end
      3'b010: sz = 4;
      3'b100: sz = 1;
      3'b101: sz = 2;
      default: sz = 0;
    endcase
    legal = sz != 0 && !(w && f3[2]);
    e = !legal || (a % 32'(sz) != 0) || al > 32'd508;
    r = '0;
    wr = 1'b0;
    ww = '0;
    lat = (!e && w && sz < 4) ? 3 : 2;
    if (!e && !w) begin
      val = '0;
      for (int i = 0; i < sz; i++) val[8*i +: 8] = ref_mem[a + 32'(i)];
      r = (sgn && sz < 4 && val[8*sz-1]) ? val | (32'hFFFF_FFFF << (8*sz)) : val;
    end
    if (!e && w) begin
      wr = 1'b1;
      if (apply) for (int i = 0; i < sz; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
      for (int i = 0; i < 4; i++) ww[8*i +: 8] = ref_mem[al + 32'(i)];
    end
  endtask
  always @(negedge clock) begin
    if (last_rst) begin
      chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
      chk("rst_resp_error", 32'(bus.resp_error), 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    end
    if (q.size() != 0 && cyc >= q[0].n) begin
      cur = q[0];
      ev = cyc >= cur.r;
      wev = cur.w != 0 && cyc == cur.w - 1;
      chk("req_ready_busy", 32'(bus.req_ready), 32'h0);
      chk("resp_valid", 32'(bus.resp_valid), 32'(ev));
      chk("mem_wen", 32'(bus.mem_wen), 32'(wev));
      if (ev) begin
        chk("resp_rdata", bus.resp_rdata, cur.rdata);
        chk("resp_error", 32'(bus.resp_error), 32'(cur.err));
      end
      if (wev) begin
        chk("mem_addr", bus.mem_addr, cur.waddr);
        chk("mem_wdata", bus.mem_wdata, cur.wword);
      end
      if (ev && bus.resp_ready) void'(q.pop_front());
    end else begin
      chk("req_ready_idle", 32'(bus.req_ready), 32'h1);
      chk("resp_valid_idle", 32'(bus.resp_valid), 32'h0);
      chk("mem_wen_idle", 32'(bus.mem_wen), 32'h0);
    end
    if (reset) q.delete();
  end
  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL response_timeout: %0d responses outstanding after 100 cycles", q.size());
      q.delete();
    end
  endtask
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] lit_r, input logic lit_e,
                       input int hold, input bit drop);
    logic [31:0] r, ww;
    logic e;
    int lat, t;
    bit wr;
    tx_t x;
    drain();
    model(w, f3, a, d, !drop, r, e, lat, wr, ww);
    chk("model_rdata", r, lit_r);
    chk("model_error", 32'(e), 32'(lit_e));
    bus.req_write = w;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    if (hold > 0) bus.resp_ready = 1'b0;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!bus.req_ready && t < 50);
    if (!bus.req_ready) begin
      nvec++;
      nerr++;
      $display("FAIL accept_timeout: req_ready 0 expected 1 for 50 cycles");
      bus.req_valid = 1'b0;
      bus.resp_ready = 1'b1;
      return;
    end
    x.n = cyc + 1;
    x.r = drop ? 32'h3FFF_FFFF : x.n + lat;
    x.w = (wr && !drop) ? x.n + lat : 0;
    x.rdata = r;
    x.err = e;
    x.waddr = a & ~32'd3;
    x.wword = ww;
    q.push_back(x);
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    if (drop) begin
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
    end else if (hold > 0) begin
      repeat (lat + hold) @(posedge clock);
      #1;
      bus.resp_ready = 1'b1;
    end
  endtask
  initial begin
    int bad;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    issue(1'b1, F3_W, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 0, 1'b0);
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'h1122_3344, 1'b0, 0, 1'b0);
    drain();
    chk("mem_byte_10", 32'(mem[16]), 32'h44);
    issue(1'b1, F3_W, 32'h20, 32'h80FF_7F01, 32'h0, 1'b0, 0, 1'b0);
    issue(1'b0, F3_B, 32'h22, 32'h0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    issue(1'b0, F3_BU, 32'h23, 32'h0, 32'h0000_0080, 1'b0, 0, 1'b0);
    issue(1'b0, F3_H, 32'h22, 32'h0, 32'hFFFF_80FF, 1'b0, 0, 1'b0);
    issue(1'b0, F3_HU, 32'h20, 32'h0, 32'h0000_7F01, 1'b0, 0, 1'b0);
    issue(1'b1, F3_B, 32'h21, 32'h0000_0055, 32'h0, 1'b0, 0, 1'b0);
    issue(1'b0, F3_W, 32'h20, 32'h0, 32'h80FF_5501, 1'b0, 0, 1'b0);
    drain();
    chk("mem_byte_21", 32'(mem[33]), 32'h55);
    issue(1'b0, F3_W, 32'h22, 32'h0, 32'h0, 1'b1, 0, 1'b0);
    issue(1'b1, F3_H, 32'h11, 32'h0000_AAAA, 32'h0, 1'b1, 0, 1'b0);
    issue(1'b0, F3_B, 32'h200, 32'h0, 32'h0, 1'b1, 0, 1'b0);
    issue(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 0, 1'b0);
    issue(1'b1, F3_BU, 32'h30, 32'h0000_00AA, 32'h0, 1'b1, 0, 1'b0);
    issue(1'b1, F3_W, 32'h1FC, 32'hA1B2_C3D4, 32'h0, 1'b0, 0, 1'b0);
    issue(1'b0, F3_B, 32'h1FF, 32'h0, 32'hFFFF_FFA1, 1'b0, 0, 1'b0);
    issue(1'b0, F3_HU, 32'h1FE, 32'h0, 32'h0000_A1B2, 1'b0, 0, 1'b0);
    issue(1'b1, F3_H, 32'h12, 32'h0000_BEEF, 32'h0, 1'b0, 0, 1'b0);
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'hBEEF_3344, 1'b0, 5, 1'b0);
    issue(1'b1, F3_B, 32'h20, 32'h0000_0099, 32'h0, 1'b0, 0, 1'b1);
    issue(1'b0, F3_W, 32'h20, 32'h0, 32'h80FF_5501, 1'b0, 0, 1'b0);
    drain();
    repeat (2) @(posedge clock);
    #1;
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad++;
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL mem_image: %0d bytes differ, expected 0", bad);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
